// File: rtl/br_arb_escritura.sv
// Write-port arbiter for the 32x32 register bank BR.
// Two writeback requesters (0: ALU, 1: load unit) share BR's single write
// port through a valid/ready handshake. The winning write is registered and
// drives a3/wd3/we directly, so it lands in BR one edge after the transfer.
module br_arb_escritura #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned ADDR_W       = 5,
   parameter bit          ZERO_PROTECT = 1'b1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              hold,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              br_we,
   output logic [ADDR_W-1:0] br_a3,
   output logic [DATA_W-1:0] br_wd3,
   output logic              last_grant,
   output logic [CNT_W-1:0]  wr_count
);

   logic              br_we_q, br_we_d;
   logic [ADDR_W-1:0] br_a3_q, br_a3_d;
   logic [DATA_W-1:0] br_wd3_q, br_wd3_d;
   logic              last_grant_q, last_grant_d;
   logic [CNT_W-1:0]  wr_count_q, wr_count_d;

   logic              grant0, grant1;
   logic              xfer;
   logic              sel_id;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              suppress;

   // Round-robin grant: a lone requester always wins; under contention the
   // requester that did not win last time goes first.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && !hold) begin
         if (req0_valid && req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
         end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // Grants already imply valid, so a grant is a transfer.
   assign xfer     = grant0 | grant1;
   assign sel_id   = grant1;
   assign sel_addr = grant1 ? req1_addr : req0_addr;
   assign sel_data = grant1 ? req1_data : req0_data;
   // Register 0 is hard-wired; the write completes its handshake but never
   // reaches BR nor counts as committed.
   assign suppress = ZERO_PROTECT && (sel_addr == '0);

   // Next-state for the registered write port, grant history and counter.
   always_comb begin
      br_we_d      = 1'b0;
      br_a3_d      = br_a3_q;
      br_wd3_d     = br_wd3_q;
      last_grant_d = last_grant_q;
      wr_count_d   = wr_count_q;
      if (xfer) begin
         br_a3_d      = sel_addr;
         br_wd3_d     = sel_data;
         last_grant_d = sel_id;
         if (!suppress) begin
            br_we_d    = 1'b1;
            wr_count_d = wr_count_q + CNT_W'(1);
         end
      end
   end

   // State registers with synchronous active-low reset; a reset drops any
   // write that was about to issue.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_we_q      <= 1'b0;
         br_a3_q      <= '0;
         br_wd3_q     <= '0;
         last_grant_q <= 1'b1;
         wr_count_q   <= '0;
      end else begin
         br_we_q      <= br_we_d;
         br_a3_q      <= br_a3_d;
         br_wd3_q     <= br_wd3_d;
         last_grant_q <= last_grant_d;
         wr_count_q   <= wr_count_d;
      end
   end

   assign br_we      = br_we_q;
   assign br_a3      = br_a3_q;
   assign br_wd3     = br_wd3_q;
   assign last_grant = last_grant_q;
   assign wr_count   = wr_count_q;

endmodule
